// File: rtl/pipe_csa_adder.sv
// Pipelined add/subtract: one SW-bit slice resolved per stage,
// slice carry handed forward between pipeline registers.
module pipe_csa_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int NX = LO + SW;

    logic [WIDTH-1:LO] a_s;
    logic [WIDTH-1:LO] b_s;
    logic              c_s;
    logic              v_s;
    logic [SW:0]       add_s;
    logic [NX-1:0]     nsum;
    logic [NX-1:0]     sum_d;
    logic [NX-1:0]     sum_q;
    logic              vld_d;
    logic              vld_q;
    logic              cry_d;
    logic              cry_q;

    if (k == 0) begin : g_src
      assign a_s  = a;
      assign b_s  = sub ? ~b : b;
      assign c_s  = sub ? 1'b1 : c_in;
      assign v_s  = in_valid;
      assign nsum = add_s[SW-1:0];
    end else begin : g_src
      assign a_s  = g_st[k-1].g_fwd.a_q;
      assign b_s  = g_st[k-1].g_fwd.b_q;
      assign c_s  = g_st[k-1].cry_q;
      assign v_s  = g_st[k-1].vld_q;
      assign nsum = {add_s[SW-1:0], g_st[k-1].sum_q};
    end

    assign add_s = {1'b0, a_s[NX-1:LO]}
                 + {1'b0, b_s[NX-1:LO]}
                 + {{SW{1'b0}}, c_s};

    always_comb begin
      vld_d = vld_q;
      cry_d = cry_q;
      sum_d = sum_q;
      if (adv) begin
        vld_d = v_s;
        cry_d = add_s[SW];
        sum_d = nsum;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cry_q <= cry_d;
        sum_q <= sum_d;
      end
    end

    // Only the still-unprocessed upper slices travel forward
    if (k < L) begin : g_fwd
      logic [WIDTH-1:NX] a_d;
      logic [WIDTH-1:NX] a_q;
      logic [WIDTH-1:NX] b_d;
      logic [WIDTH-1:NX] b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_s[WIDTH-1:NX];
          b_d = b_s[WIDTH-1:NX];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  logic ovf_d;
  logic ovf_q;
  logic zero_d;
  logic zero_q;

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv) begin
      ovf_d  = (g_st[L].a_s[WIDTH-1] == g_st[L].b_s[WIDTH-1])
            && (g_st[L].add_s[SW-1] != g_st[L].a_s[WIDTH-1]);
      zero_d = ~|g_st[L].nsum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = g_st[L].vld_q;
  assign sum       = g_st[L].sum_q;
  assign c_out     = g_st[L].cry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
